uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised successor to the team's single-byte UART receiver. It deserialises asynchronous frames (7/8 data bits, optional parity with even/odd select, one stop bit) using a 3-sample majority vote at each bit centre. It detects glitched starts and line breaks, and queues each received byte with its per-byte error flags in a DEPTH-entry first-word-fall-through FIFO. It sits between the pad-side `rx` line and the host register interface, replacing the single holding register so the host can tolerate bursts.

## Interface
- KW, 19, width of bit-time divisor `k`
- DEPTH, 4, FIFO entries; power of 2, ≥2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- k  in  KW  clocks per bit; legal range 4..2^KW-1
- eight  in  1  1 = 8 data bits, 0 = 7
- parity_en  in  1  parity bit present
- ohel  in  1  1 = odd parity, 0 = even
- rx  in  1  serial line, asynchronous, idle high
- rd  in  1  pop head entry (one pulse = one entry)
- clr  in  1  synchronous flush of FIFO and OVF
- data  out  8  head byte; bit 7 = 0 in 7-bit mode
- PERR  out  1  head entry parity error (only when parity_en was 1 at capture)
- FERR  out  1  head entry stop bit sampled 0
- BRK  out  1  head entry is a break
- RXRDY  out  1  FIFO non-empty
- OVF  out  1  sticky: a frame was dropped because the FIFO was full
- count  out  $clog2(DEPTH)+1  entries held

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1), then a 3-deep history. Sampled bit = majority of the 3 most recent synchronised values.
- Bit-time counter runs 0..k-1. Tick when counter == k-1, then the counter reloads to 0. In START, the tick is instead taken at (k>>1)-1.
- FSM states:
  - IDLE: counter held 0. Go to START when synchronised `rx` = 0.
  - START: at half-bit tick, if the voted sample is 1, treat it as a glitch and return to IDLE with nothing pushed. Otherwise go to DATA.
  - DATA: shift the voted sample in LSB first on each tick. After 7 or 8 bits, go to PAR if parity_en, else STOP.
  - PAR: capture the parity bit on its tick.
  - STOP: capture the stop bit on its tick, then perform the push. Go to IDLE, or to WAIT_HI if BRK.
  - WAIT_HI: wait for synchronised `rx` = 1, then go to IDLE.
- Parity check:
  - Even parity expects the XOR of data bits to equal the parity bit; odd parity expects its complement.
  - PERR = mismatch & parity_en.
- FERR = stop sample 0.
- BRK = all data bits, the parity bit (if present) and the stop bit are 0. FERR is also 1 for a break.
- Push writes the entry {BRK, FERR, PERR, data}.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is discarded and OVF is set.
- Pop: `rd` with count > 0 advances the head. `rd` with count = 0 is ignored.
- Simultaneous push and pop:
  - At full: pop retires the head, the push is accepted, count stays DEPTH, OVF is not set.
  - At empty: the push is accepted and the pop is ignored, so count = 1.
- `clr` sets count to 0, pointers to 0 and OVF to 0. `clr` wins over a same-cycle push, which is discarded, and over a same-cycle OVF set. The receive FSM is not affected by `clr`.
- Outputs data/PERR/FERR/BRK show the head entry combinationally from the storage. They are 0 when count = 0.
- Changing eight/parity_en/ohel/k mid-frame is not supported. The frame in flight may be corrupt, but the FSM must return to IDLE within one maximum frame time.

## Timing
- Reset values:
  - FSM = IDLE, synchroniser = 1, counters and pointers = 0.
  - data = 0, PERR/FERR/BRK/RXRDY/OVF = 0, count = 0.
- Reset asserted mid-frame aborts the frame. No entry is pushed after release.
- rx falling edge to START entry: 2–3 clocks (synchroniser).
- Data bit n is sampled at (k>>1) + (n+1)·k clocks after START entry.
- Stop tick to RXRDY/count update: 1 clock (registered write).
- `rd` high at edge N: the new head is visible after edge N, and count decrements at N.
- Minimum glitch rejected: low pulse shorter than about (k>>1)-2 clocks.

## Test plan
- k=16, 8N1, send 0xA5 → one push, data=0xA5, RXRDY=1, count=1, PERR=FERR=BRK=0. After `rd`: RXRDY=0, data=0.
- k=16, 7E1, send 0x41 with parity bit 1 (wrong) → data=0x41, PERR=1, FERR=0. Repeat with the correct parity bit 0 → PERR=0.
- k=16, rx low for 5 clocks then high → FSM returns to IDLE, count stays 0. Single-clock high glitch mid-bit in 0x00 → still received as 0x00 (majority vote).
- DEPTH=4, 8N1, send 0x01..0x05 without `rd` → count=4, OVF=1, data=0x01. Four pops yield 0x01..0x04. Then `clr` → OVF=0.
- FIFO full, `rd` pulsed on the same cycle as the 5th frame's push → count=4, OVF=0, head=0x02, tail=0x05.
- 8E1, rx held low for 2 frame times → one entry with BRK=1, FERR=1, data=0x00. No further push until rx returns high and a new start arrives. Assert rst mid-frame → all outputs 0, no entry after release.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Host-side register bus of the UART receiver FIFO.
//   rd, clr            : host -> receiver (pop head entry, flush FIFO and OVF)
//   data/PERR/FERR/BRK : head entry, zero when the FIFO is empty
//   RXRDY, OVF, count  : FIFO non-empty, sticky drop flag, entries held
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rd;
    logic          clr;
    logic [7:0]    data;
    logic          PERR;
    logic          FERR;
    logic          BRK;
    logic          RXRDY;
    logic          OVF;
    logic [CW-1:0] count;

    modport master (output rd, clr, input data, PERR, FERR, BRK, RXRDY, OVF, count);
    modport slave  (input rd, clr, output data, PERR, FERR, BRK, RXRDY, OVF, count);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// Deserialises 7/8-bit frames with optional even/odd parity and one stop bit,
// using a 3-sample majority vote at each bit centre, and queues each byte with
// its PERR/FERR/BRK flags in a DEPTH-entry FIFO.
//   clk, rst              : clock, asynchronous active-low reset
//   k                     : clocks per bit (4..2^KW-1)
//   eight/parity_en/ohel  : frame format (8 data bits, parity present, odd parity)
//   rx                    : asynchronous serial line, idle high
//   host                  : host bus (pop/flush in, head entry and status out)
module uart_rx_fifo #(
    parameter int KW    = 19,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] k,
    input  logic          eight,
    input  logic          parity_en,
    input  logic          ohel,
    input  logic          rx,
    uart_rx_fifo_if.slave host
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI} state_t;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

    // ---------------- synchroniser and majority vote ----------------
    logic       s1, s2;
    logic [2:0] hist;
    logic       vote;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            hist <= 3'b111;
        end else begin
            s1   <= rx;
            s2   <= s1;
            hist <= {hist[1:0], s2};
        end
    end

    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    // ---------------- bit-time counter ----------------
    state_t        state, state_nx;
    logic [KW-1:0] bcnt;
    logic [KW-1:0] half_m1, full_m1;
    logic          tick;

    assign half_m1 = (k >> 1) - KW'(1);
    assign full_m1 = k - KW'(1);
    // Compare with >= so a k reduced mid-frame still ticks promptly
    // instead of wrapping the whole counter range.
    assign tick = (state == S_START) ? (bcnt >= half_m1) : (bcnt >= full_m1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bcnt <= '0;
        else if (state == S_IDLE || state == S_WAIT_HI || tick)
            bcnt <= '0;
        else
            bcnt <= bcnt + KW'(1);
    end

    // ---------------- receive datapath ----------------
    logic [2:0] nbit;
    logic [7:0] shreg;
    logic       parbit;
    logic       last_bit;
    logic [7:0] rx_byte;
    entry_t     ent;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nbit   <= '0;
            shreg  <= '0;
            parbit <= 1'b0;
        end else begin
            if (state == S_START)
                nbit <= '0;
            else if (state == S_DATA && tick) begin
                shreg <= {vote, shreg[7:1]};
                nbit  <= nbit + 3'd1;
            end
            if (state == S_PAR && tick)
                parbit <= vote;
        end
    end

    assign last_bit = nbit >= (eight ? 3'd7 : 3'd6);
    // In 7-bit mode the byte has only been shifted 7 places, so it sits in [7:1].
    assign rx_byte  = eight ? shreg : {1'b0, shreg[7:1]};

    // Entry is assembled while the stop-bit vote is live on the stop tick.
    always_comb begin
        ent.data = rx_byte;
        ent.perr = parity_en & (parbit != ((^rx_byte) ^ ohel));
        ent.ferr = ~vote;
        ent.brk  = (rx_byte == 8'h00) & ~(parity_en & parbit) & ~vote;
    end

    // ---------------- receive FSM ----------------
    logic push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        case (state)
            S_IDLE:    if (!s2) state_nx = S_START;
            S_START:   if (tick) state_nx = vote ? S_IDLE : S_DATA;
            S_DATA:    if (tick && last_bit) state_nx = parity_en ? S_PAR : S_STOP;
            S_PAR:     if (tick) state_nx = S_STOP;
            S_STOP: begin
                if (tick) begin
                    push     = 1'b1;
                    state_nx = ent.brk ? S_WAIT_HI : S_IDLE;
                end
            end
            S_WAIT_HI: if (s2) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    entry_t        mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          full, do_pop, do_push;
    entry_t        head;

    assign full    = (cnt == FULL);
    assign do_pop  = host.rd && (cnt != '0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && !host.clr && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (host.clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (do_pop)  rp <= rp + AW'(1);
            if (do_push) wp <= wp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
            if (push && full && !do_pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= ent;
    end

    assign head       = mem[rp];
    assign host.data  = (cnt != '0) ? head.data : 8'h00;
    assign host.PERR  = (cnt != '0) & head.perr;
    assign host.FERR  = (cnt != '0) & head.ferr;
    assign host.BRK   = (cnt != '0) & head.brk;
    assign host.RXRDY = (cnt != '0);
    assign host.OVF   = ovf;
    assign host.count = cnt;
endmodule
